// File: rtl/seq_perceptron_if.sv
// Stream and configuration bundle for seq_perceptron: forward, prediction,
// backward and error handshakes plus the weight load port. Numbers are Q8.8.
interface seq_perceptron_if #(
    parameter int INPUT_UNITS  = 4,
    parameter int OUTPUT_UNITS = 2
);
    // One spare address bit so that addresses past the bias slot are representable
    localparam int AW = $clog2(INPUT_UNITS + 1) + 1;

    logic                           in_valid;
    logic                           in_ready;
    logic [INPUT_UNITS-1:0][15:0]   values;
    logic [1:0]                     activation;
    logic                           training;
    logic [15:0]                    learning_rate;
    logic                           out_valid;
    logic                           out_ready;
    logic [15:0]                    prediction;
    logic                           grad_valid;
    logic                           grad_ready;
    logic [OUTPUT_UNITS-1:0][15:0]  next_layer_weights;
    logic [OUTPUT_UNITS-1:0][15:0]  error_gradient_next_layer;
    logic                           err_valid;
    logic [15:0]                    error_gradient;
    logic [INPUT_UNITS-1:0][15:0]   current_weights;
    logic                           wr_en;
    logic [AW-1:0]                  wr_addr;
    logic [15:0]                    wr_data;
    logic                           busy;

    modport slave (
        input  in_valid, values, activation, training, learning_rate,
        input  out_ready, grad_valid, next_layer_weights, error_gradient_next_layer,
        input  wr_en, wr_addr, wr_data,
        output in_ready, out_valid, prediction, grad_ready, err_valid,
        output error_gradient, current_weights, busy
    );

    modport master (
        output in_valid, values, activation, training, learning_rate,
        output out_ready, grad_valid, next_layer_weights, error_gradient_next_layer,
        output wr_en, wr_addr, wr_data,
        input  in_ready, out_valid, prediction, grad_ready, err_valid,
        input  error_gradient, current_weights, busy
    );
endinterface

// File: rtl/seq_perceptron.sv
// Time-multiplexed perceptron neuron: forward pass over LANES shared MACs,
// optional backward pass and weight update. Saturating Q8.8 arithmetic throughout.
module seq_perceptron #(
    parameter int INPUT_UNITS  = 4,
    parameter int OUTPUT_UNITS = 2,
    parameter int LANES        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_perceptron_if.slave   io_nrn
);
    typedef logic signed [15:0] sfp_t;

    localparam int K       = (INPUT_UNITS + LANES - 1) / LANES;
    localparam int CNT_MAX = (K > OUTPUT_UNITS) ? K : OUTPUT_UNITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] ACT_LINEAR  = 2'd0;
    localparam logic [1:0] ACT_SIGMOID = 2'd1;
    localparam logic [1:0] ACT_TANH    = 2'd2;
    localparam logic [1:0] ACT_RELU    = 2'd3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FWD       = 3'd1;
    localparam logic [2:0] S_OUT       = 3'd2;
    localparam logic [2:0] S_WAIT_GRAD = 3'd3;
    localparam logic [2:0] S_BWD       = 3'd4;
    localparam logic [2:0] S_UPD       = 3'd5;

    localparam sfp_t SFP_ZERO = 16'sd0;
    localparam sfp_t SFP_HALF = 16'sd128;
    localparam sfp_t SFP_ONE  = 16'sd256;

    function automatic sfp_t sfp_sat(input logic signed [32:0] x);
        if (x > 33'sd32767) begin
            return 16'sh7fff;
        end else if (x < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

    function automatic sfp_t sfp_add(input sfp_t a, input sfp_t b);
        logic signed [32:0] t;
        t = 33'(a) + 33'(b);
        return sfp_sat(t);
    endfunction

    function automatic sfp_t sfp_sub(input sfp_t a, input sfp_t b);
        logic signed [32:0] t;
        t = 33'(a) - 33'(b);
        return sfp_sat(t);
    endfunction

    // Round half up, then drop the 8 fraction bits of the double-width product
    function automatic sfp_t sfp_mul(input sfp_t a, input sfp_t b);
        logic signed [32:0] p;
        p = 33'(a) * 33'(b);
        p = (p + 33'sd128) >>> 8;
        return sfp_sat(p);
    endfunction

    // Sigmoid and tanh are the hard (piecewise-linear) forms
    function automatic sfp_t predict(input logic [1:0] act, input sfp_t x);
        sfp_t y;
        case (act)
            ACT_SIGMOID: begin
                y = sfp_add(SFP_HALF, x >>> 2);
                if (y < SFP_ZERO)     y = SFP_ZERO;
                else if (y > SFP_ONE) y = SFP_ONE;
                else                  y = y;
            end
            ACT_TANH: begin
                if (x < -SFP_ONE)     y = -SFP_ONE;
                else if (x > SFP_ONE) y = SFP_ONE;
                else                  y = x;
            end
            ACT_RELU: y = (x < SFP_ZERO) ? SFP_ZERO : x;
            default:  y = x;
        endcase
        return y;
    endfunction

    function automatic sfp_t deriv(input logic [1:0] act, input sfp_t p, input sfp_t s);
        sfp_t d;
        case (act)
            ACT_SIGMOID: d = sfp_mul(p, sfp_sub(SFP_ONE, p));
            ACT_TANH:    d = sfp_sub(SFP_ONE, sfp_mul(p, p));
            ACT_RELU:    d = (s >= SFP_ZERO) ? SFP_ONE : SFP_ZERO;
            default:     d = SFP_ZERO;
        endcase
        return d;
    endfunction

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_idx;
    sfp_t             r_w   [INPUT_UNITS];
    sfp_t             r_v   [INPUT_UNITS];
    sfp_t             r_nw  [OUTPUT_UNITS];
    sfp_t             r_egn [OUTPUT_UNITS];
    sfp_t             r_bias, r_lr, r_sum, r_acc, r_pred, r_eg;
    logic [1:0]       r_act;
    logic             r_train;
    logic             r_errv;

    int               w_base;
    logic             w_last_k, w_last_o;
    sfp_t             w_lane_w  [LANES];
    sfp_t             w_lane_v  [LANES];
    sfp_t             w_lane_new[LANES];
    sfp_t             w_w_next  [INPUT_UNITS];
    sfp_t             w_fwd_sum, w_nw_sel, w_eg_sel, w_deriv, w_bwd_acc;

    // Lane operand steering, shared MAC datapath and next-state values for all passes
    always_comb begin
        w_base    = int'(r_idx) * LANES;
        w_last_k  = (int'(r_idx) == K - 1);
        w_last_o  = (int'(r_idx) == OUTPUT_UNITS - 1);
        w_fwd_sum = r_sum;
        for (int l = 0; l < LANES; l++) begin
            w_lane_w[l] = SFP_ZERO;
            w_lane_v[l] = SFP_ZERO;
            for (int i = 0; i < INPUT_UNITS; i++) begin
                w_lane_w[l] = (i == w_base + l) ? r_w[i] : w_lane_w[l];
                w_lane_v[l] = (i == w_base + l) ? r_v[i] : w_lane_v[l];
            end
            // Lanes past the last input see zero operands and add nothing
            w_fwd_sum     = sfp_add(w_fwd_sum, sfp_mul(w_lane_w[l], w_lane_v[l]));
            w_lane_new[l] = sfp_sub(w_lane_w[l], sfp_mul(r_lr, sfp_mul(r_eg, w_lane_v[l])));
        end
        for (int i = 0; i < INPUT_UNITS; i++) begin
            w_w_next[i] = r_w[i];
            for (int l = 0; l < LANES; l++) begin
                w_w_next[i] = (i == w_base + l) ? w_lane_new[l] : w_w_next[i];
            end
        end
        w_nw_sel = SFP_ZERO;
        w_eg_sel = SFP_ZERO;
        for (int j = 0; j < OUTPUT_UNITS; j++) begin
            w_nw_sel = (j == int'(r_idx)) ? r_nw[j]  : w_nw_sel;
            w_eg_sel = (j == int'(r_idx)) ? r_egn[j] : w_eg_sel;
        end
        w_deriv   = deriv(r_act, r_pred, r_sum);
        w_bwd_acc = sfp_add(r_acc, sfp_mul(w_nw_sel, sfp_mul(w_eg_sel, w_deriv)));
    end

    // Sequencer and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bias  <= SFP_ZERO;
            r_lr    <= SFP_ZERO;
            r_sum   <= SFP_ZERO;
            r_acc   <= SFP_ZERO;
            r_pred  <= SFP_ZERO;
            r_eg    <= SFP_ZERO;
            r_act   <= 2'd0;
            r_train <= 1'b0;
            r_errv  <= 1'b0;
            for (int i = 0; i < INPUT_UNITS; i++) begin
                r_w[i] <= SFP_ZERO;
                r_v[i] <= SFP_ZERO;
            end
            for (int j = 0; j < OUTPUT_UNITS; j++) begin
                r_nw[j]  <= SFP_ZERO;
                r_egn[j] <= SFP_ZERO;
            end
        end else begin
            r_errv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_nrn.wr_en) begin
                        for (int i = 0; i < INPUT_UNITS; i++) begin
                            if (int'(io_nrn.wr_addr) == i) r_w[i] <= io_nrn.wr_data;
                        end
                        if (int'(io_nrn.wr_addr) == INPUT_UNITS) r_bias <= io_nrn.wr_data;
                    end
                    if (io_nrn.in_valid) begin
                        for (int i = 0; i < INPUT_UNITS; i++) r_v[i] <= io_nrn.values[i];
                        r_act   <= io_nrn.activation;
                        r_train <= io_nrn.training;
                        r_lr    <= io_nrn.learning_rate;
                        r_sum   <= r_bias;
                        r_idx   <= '0;
                        r_state <= S_FWD;
                    end
                end
                S_FWD: begin
                    r_sum <= w_fwd_sum;
                    if (w_last_k) begin
                        r_pred  <= predict(r_act, w_fwd_sum);
                        r_idx   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (io_nrn.out_ready) r_state <= r_train ? S_WAIT_GRAD : S_IDLE;
                end
                S_WAIT_GRAD: begin
                    if (io_nrn.grad_valid) begin
                        for (int j = 0; j < OUTPUT_UNITS; j++) begin
                            r_nw[j]  <= io_nrn.next_layer_weights[j];
                            r_egn[j] <= io_nrn.error_gradient_next_layer[j];
                        end
                        r_acc   <= SFP_ZERO;
                        r_idx   <= '0;
                        r_state <= S_BWD;
                    end
                end
                S_BWD: begin
                    r_acc <= w_bwd_acc;
                    if (w_last_o) begin
                        r_eg    <= w_bwd_acc;
                        r_errv  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_UPD;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                S_UPD: begin
                    for (int i = 0; i < INPUT_UNITS; i++) r_w[i] <= w_w_next[i];
                    if (w_last_k) begin
                        r_bias  <= sfp_sub(r_bias, sfp_mul(r_lr, r_eg));
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register so reset takes effect without a clock
    always_comb begin
        io_nrn.in_ready       = (r_state == S_IDLE);
        io_nrn.out_valid      = (r_state == S_OUT);
        io_nrn.grad_ready     = (r_state == S_WAIT_GRAD);
        io_nrn.busy           = (r_state != S_IDLE);
        io_nrn.err_valid      = r_errv;
        io_nrn.prediction     = r_pred;
        io_nrn.error_gradient = r_eg;
        for (int i = 0; i < INPUT_UNITS; i++) io_nrn.current_weights[i] = r_w[i];
    end
endmodule

// File: tb/tb_seq_perceptron.sv
// Directed bench for seq_perceptron (INPUT_UNITS=3, OUTPUT_UNITS=2, LANES=2) with
// hand-computed Q8.8 expectations.
module tb_seq_perceptron;
    localparam int IU = 3;
    localparam int OU = 2;

    localparam logic [1:0] ACT_LIN  = 2'd0;
    localparam logic [1:0] ACT_SIG  = 2'd1;
    localparam logic [1:0] ACT_RELU = 2'd3;

    localparam logic [15:0] Q_0     = 16'h0000;
    localparam logic [15:0] Q_1     = 16'h0100;
    localparam logic [15:0] Q_2     = 16'h0200;
    localparam logic [15:0] Q_P5    = 16'h0080;
    localparam logic [15:0] Q_P25   = 16'h0040;
    localparam logic [15:0] Q_P125  = 16'h0020;
    localparam logic [15:0] Q_P625  = 16'h00A0;
    localparam logic [15:0] Q_P75   = 16'h00C0;
    localparam logic [15:0] Q_M25   = 16'hFFC0;
    localparam logic [15:0] Q_M1P25 = 16'hFEC0;
    localparam logic [15:0] Q_MP375 = 16'hFFA0;
    localparam logic [15:0] Q_MP125 = 16'hFFE0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seq_perceptron_if #(.INPUT_UNITS(IU), .OUTPUT_UNITS(OU)) bus ();

    seq_perceptron #(.INPUT_UNITS(IU), .OUTPUT_UNITS(OU), .LANES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_nrn (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic load_std();
        wr(3'd0, Q_P5); wr(3'd1, Q_M25); wr(3'd2, Q_1); wr(3'd3, Q_P125);
    endtask

    task automatic fwd_start(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                             input logic [1:0] act, input logic train, input logic [15:0] lr);
        bus.values[0] = v0; bus.values[1] = v1; bus.values[2] = v2;
        bus.activation = act; bus.training = train; bus.learning_rate = lr;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic grad_start(input logic [15:0] nw0, input logic [15:0] nw1,
                              input logic [15:0] eg0, input logic [15:0] eg1);
        bus.next_layer_weights[0] = nw0; bus.next_layer_weights[1] = nw1;
        bus.error_gradient_next_layer[0] = eg0; bus.error_gradient_next_layer[1] = eg1;
        bus.grad_valid = 1'b1;
        tick();
        bus.grad_valid = 1'b0;
    endtask

    task automatic finish_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.grad_ready !== 1'b0 || bus.err_valid !== 1'b0) begin
            $display("FAIL reset_flags: got rdy=%b busy=%b ov=%b gr=%b ev=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.grad_ready, bus.err_valid);
            failures++;
        end
        checks++;
        if (bus.prediction !== Q_0 || bus.error_gradient !== Q_0 || bus.current_weights !== 48'h0) begin
            $display("FAIL reset_data: got pred=%h eg=%h w=%h, want zeros",
                     bus.prediction, bus.error_gradient, bus.current_weights);
            failures++;
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_reset();
        load_std();
        checks++;
        if (bus.current_weights !== {Q_1, Q_M25, Q_P5}) begin
            $display("FAIL load_weights: got %h, want %h", bus.current_weights, {Q_1, Q_M25, Q_P5});
            failures++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.current_weights !== 48'h0 || bus.in_ready !== 1'b1) begin
            $display("FAIL async_reset_clear: got w=%h rdy=%b, want 0 and 1",
                     bus.current_weights, bus.in_ready);
            failures++;
        end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_relu_fwd();
        load_std();
        fwd_start(Q_1, Q_2, Q_P5, ACT_RELU, 1'b0, Q_0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL fwd_accept: got rdy=%b busy=%b ov=%b, want 0 1 0",
                     bus.in_ready, bus.busy, bus.out_valid);
            failures++;
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL fwd_early_valid: got ov=%b after E+1, want 0", bus.out_valid);
            failures++;
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.prediction !== Q_P625) begin
            $display("FAIL relu_pred: got ov=%b pred=%h, want 1 %h", bus.out_valid, bus.prediction, Q_P625);
            failures++;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.prediction !== Q_P625) begin
                $display("FAIL pred_hold: cycle %0d got ov=%b pred=%h, want 1 %h",
                         c, bus.out_valid, bus.prediction, Q_P625);
                failures++;
            end
        end
        finish_out();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.grad_ready !== 1'b0) begin
            $display("FAIL infer_return: got rdy=%b ov=%b gr=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.grad_ready);
            failures++;
        end
    endtask

    task automatic test_training();
        fwd_start(Q_1, Q_2, Q_P5, ACT_RELU, 1'b1, Q_P5);
        tick(); tick();
        finish_out();
        checks++;
        if (bus.grad_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
            $display("FAIL wait_grad: got gr=%b rdy=%b, want 1 0", bus.grad_ready, bus.in_ready);
            failures++;
        end
        grad_start(Q_1, Q_P5, Q_P5, Q_1);
        checks++;
        if (bus.err_valid !== 1'b0) begin
            $display("FAIL err_early_g0: got ev=%b, want 0", bus.err_valid);
            failures++;
        end
        tick();
        checks++;
        if (bus.err_valid !== 1'b0) begin
            $display("FAIL err_early_g1: got ev=%b, want 0", bus.err_valid);
            failures++;
        end
        tick();
        checks++;
        if (bus.err_valid !== 1'b1 || bus.error_gradient !== Q_1 || bus.current_weights[0] !== Q_P5) begin
            $display("FAIL err_pulse: got ev=%b eg=%h w0=%h, want 1 %h %h",
                     bus.err_valid, bus.error_gradient, bus.current_weights[0], Q_1, Q_P5);
            failures++;
        end
        tick();
        checks++;
        if (bus.err_valid !== 1'b0 || bus.current_weights !== {Q_1, Q_M1P25, Q_0} || bus.in_ready !== 1'b0) begin
            $display("FAIL upd_first: got ev=%b w=%h rdy=%b, want 0 %h 0",
                     bus.err_valid, bus.current_weights, bus.in_ready, {Q_1, Q_M1P25, Q_0});
            failures++;
        end
        tick();
        checks++;
        if (bus.current_weights !== {Q_P75, Q_M1P25, Q_0} || bus.in_ready !== 1'b1 ||
            bus.error_gradient !== Q_1) begin
            $display("FAIL upd_last: got w=%h rdy=%b eg=%h, want %h 1 %h",
                     bus.current_weights, bus.in_ready, bus.error_gradient, {Q_P75, Q_M1P25, Q_0}, Q_1);
            failures++;
        end
        fwd_start(Q_0, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        tick(); tick();
        checks++;
        if (bus.prediction !== Q_MP375) begin
            $display("FAIL bias_update: got %h, want %h", bus.prediction, Q_MP375);
            failures++;
        end
        finish_out();
    endtask

    task automatic test_sigmoid();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        fwd_start(Q_0, Q_0, Q_0, ACT_SIG, 1'b1, Q_P5);
        tick(); tick();
        checks++;
        if (bus.prediction !== Q_P5) begin
            $display("FAIL sigmoid_pred: got %h, want %h", bus.prediction, Q_P5);
            failures++;
        end
        finish_out();
        grad_start(Q_1, Q_0, Q_1, Q_0);
        tick(); tick();
        checks++;
        if (bus.err_valid !== 1'b1 || bus.error_gradient !== Q_P25) begin
            $display("FAIL sigmoid_grad: got ev=%b eg=%h, want 1 %h", bus.err_valid, bus.error_gradient, Q_P25);
            failures++;
        end
        tick(); tick();
        fwd_start(Q_0, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        tick(); tick();
        checks++;
        if (bus.prediction !== Q_MP125) begin
            $display("FAIL sigmoid_bias: got %h, want %h", bus.prediction, Q_MP125);
            failures++;
        end
        finish_out();
    endtask

    task automatic test_wr_busy();
        wr(3'd0, Q_P5);
        fwd_start(Q_0, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'h0300;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.current_weights[0] !== Q_P5) begin
            $display("FAIL wr_in_fwd: got w0=%h, want %h", bus.current_weights[0], Q_P5);
            failures++;
        end
        tick();
        finish_out();
        wr(3'd4, 16'h7777);
        checks++;
        if (bus.current_weights !== {Q_0, Q_0, Q_P5}) begin
            $display("FAIL wr_bad_addr: got w=%h, want %h", bus.current_weights, {Q_0, Q_0, Q_P5});
            failures++;
        end
        fwd_start(Q_0, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        tick(); tick();
        checks++;
        if (bus.prediction !== Q_MP125) begin
            $display("FAIL wr_bad_addr_bias: got %h, want %h", bus.prediction, Q_MP125);
            failures++;
        end
        finish_out();
    endtask

    task automatic test_mid_reset();
        int ev_seen;
        ev_seen = 0;
        load_std();
        fwd_start(Q_1, Q_2, Q_P5, ACT_RELU, 1'b1, Q_P5);
        tick(); tick();
        finish_out();
        grad_start(Q_1, Q_P5, Q_P5, Q_1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.grad_ready !== 1'b0 ||
            bus.current_weights !== 48'h0) begin
            $display("FAIL mid_reset: got rdy=%b busy=%b gr=%b w=%h, want 1 0 0 0",
                     bus.in_ready, bus.busy, bus.grad_ready, bus.current_weights);
            failures++;
        end
        for (int c = 0; c < 4; c++) begin
            if (bus.err_valid === 1'b1) ev_seen++;
            tick();
            rst_n = 1'b1;
        end
        checks++;
        if (ev_seen !== 0 || bus.error_gradient !== Q_0) begin
            $display("FAIL mid_reset_err: got pulses=%0d eg=%h, want 0 %h", ev_seen, bus.error_gradient, Q_0);
            failures++;
        end
        fwd_start(Q_1, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL post_reset_accept: got rdy=%b busy=%b, want 0 1", bus.in_ready, bus.busy);
            failures++;
        end
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.prediction !== Q_0) begin
            $display("FAIL post_reset_pred: got ov=%b pred=%h, want 1 %h", bus.out_valid, bus.prediction, Q_0);
            failures++;
        end
        finish_out();
    endtask

    task automatic test_back_to_back();
        wr(3'd0, Q_1);
        fwd_start(Q_1, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        tick(); tick();
        finish_out();
        fwd_start(Q_2, Q_0, Q_0, ACT_LIN, 1'b0, Q_0);
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL b2b_accept: got busy=%b, want 1", bus.busy);
            failures++;
        end
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.prediction !== Q_2) begin
            $display("FAIL b2b_pred: got ov=%b pred=%h, want 1 %h", bus.out_valid, bus.prediction, Q_2);
            failures++;
        end
        finish_out();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.grad_valid = 1'b0; bus.wr_en = 1'b0;
        bus.wr_addr = 3'd0; bus.wr_data = 16'h0; bus.values = '0; bus.activation = 2'd0;
        bus.training = 1'b0; bus.learning_rate = 16'h0;
        bus.next_layer_weights = '0; bus.error_gradient_next_layer = '0;
        test_reset();
        test_load_reset();
        test_relu_fwd();
        test_training();
        test_sigmoid();
        test_wr_busy();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
